// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the rv64 core.
// Define CORE_SEQ_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module core_sequencer #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    input  logic            dec_reg_write,
    input  logic            dec_illegal,
    output logic [XLEN-1:0] pc,
    output logic            ex_en,
    output logic            reg_we,
    output logic            retire,
    output logic            halted
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= NopInstr;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // An illegal opcode freezes pc/instr so software can inspect the faulting word.
                state_d = dec_illegal ? StHalt : StExecute;
            end
            StExecute: begin
                state_d = StWriteback;
            end
            StWriteback: begin
                pc_d    = pc_q + XLEN'(4);
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from registered state only; imem_ready never reaches them.
    always_comb begin
        imem_req = 1'b0;
        ex_en    = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            StFetch:     imem_req = 1'b1;
            StExecute:   ex_en = 1'b1;
            StWriteback: begin
                reg_we = dec_reg_write;
                retire = 1'b1;
            end
            StHalt:      halted = 1'b1;
            default:     ;
        endcase
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;

`ifdef CORE_SEQ_PERF_EN
    logic [63:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != StIdle && state_q != StHalt) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the rv64 core. It fetches each instruction over a request/ready instruction-memory port and holds it in an instruction register for the decoder (`controller`). It then steps the datapath through decode, execute and write-back, gates the register-file write with the decoder's `regWrite`, and advances the PC. It sits between the instruction memory and the existing decode/ALU/register-file datapath, and replaces free-running single-cycle operation with explicit, stallable phases.

## Interface
- `XLEN`, 64: PC width.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: leave IDLE and start fetching.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, equal to `pc`.
- `imem_ready` in 1: `imem_rdata` is valid this cycle and completes the request.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: instruction register, which drives the decoder.
- `dec_reg_write` in 1: decoder `regWrite`.
- `dec_illegal` in 1: decoder found an unknown instruction.
- `pc` out XLEN: current PC.
- `ex_en` out 1: one-cycle execute strobe to the ALU/operand registers.
- `reg_we` out 1: register-file write enable, one cycle.
- `retire` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: sequencer is in HALT.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT. Reset enters IDLE.
- IDLE: all strobes are 0. When `run`=1, go to FETCH on the next edge. `run` is ignored in every other state.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`. Both are held stable until `imem_ready`=1.
  - On the `imem_ready` edge, `instr` <= `imem_rdata` and the state goes to DECODE.
  - `imem_ready` outside FETCH is ignored.
- DECODE: one cycle, during which the decoder settles on a stable `instr`. At the end of the cycle, sample `dec_illegal`:
  - 1: go to HALT. `pc` and `instr` are frozen.
  - 0: go to EXECUTE.
- EXECUTE: `ex_en`=1 for exactly this cycle, then go to WRITEBACK.
- WRITEBACK:
  - `reg_we`=`dec_reg_write` and `retire`=1.
  - `pc` <= `pc`+4, modulo 2^XLEN, so `{XLEN{1}}`-3 wraps to 0.
  - Go to FETCH.
- HALT: `halted`=1 and all strobes are 0. Only reset leaves HALT.
- `reg_we`, `ex_en` and `retire` are 0 in every state other than the ones listed above.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0x00000013 (nop), and `imem_req`, `ex_en`, `reg_we`, `retire` and `halted` all 0.
- All outputs are registered or decoded purely from state. There is no combinational path from `imem_ready` to any output.
- With a zero-wait memory (`imem_ready`=1 in the first FETCH cycle), one instruction takes 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK. Each wait cycle on `imem_ready` adds one cycle.
- `retire` pulses at most once every 4 cycles.
- Reset asserted mid-operation clears everything immediately and asynchronously; an outstanding fetch is abandoned and `imem_req` falls without waiting for `imem_ready`.
- `rst_n` deasserts synchronously to `clk`. The first FETCH happens no earlier than the cycle after `run` is sampled high.

## Configuration
- `CORE_SEQ_PERF_EN` defined adds two outputs:
  - `cycle_cnt` (64): counts every cycle not in IDLE or HALT.
  - `instret_cnt` (64): increments on each `retire`.
  - Both reset to 0, wrap at 2^64, and freeze in HALT.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Zero-wait fetch of `addi x1,x0,5` (0x00500093), `dec_reg_write`=1 → `ex_en` in cycle 3 and `reg_we`=`retire`=1 in cycle 4 after FETCH entry; `pc` goes 0→4.
- `imem_ready` held low for 3 cycles → `imem_req` and `imem_addr`=0 stay stable for 4 cycles; `retire` arrives 7 cycles after FETCH entry.
- `dec_illegal`=1 during DECODE → HALT, `halted`=1, no `reg_we`/`retire`, `pc` unchanged; `imem_req` stays 0 for 20 cycles.
- `RESET_PC`=0xFFFFFFFFFFFFFFFC, one instruction → `pc` wraps to 0.
- `rst_n` pulled low while in FETCH with `imem_ready`=0 → `imem_req`=0 and `pc`=`RESET_PC` immediately; the state is IDLE after release.
- With `CORE_SEQ_PERF_EN` defined, 3 zero-wait instructions → `instret_cnt`=3 and `cycle_cnt`=12.
